// File: rtl/jam_pkg.sv
// Shared definitions for the JAM cost-lookup interface (server and solver side).
// Latency: n/a (constants, types and a pure address-packing function).
// Backpressure: n/a.
package jam_pkg;

    localparam int N  = 8;           // workers = jobs, power of 2
    localparam int CW = 7;           // cost word width
    localparam int AW = 6;           // log2(N*N)
    localparam int LW = $clog2(N);   // worker / job index width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SERVE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Row-major matrix address: worker selects the row, job the column.
    function automatic logic [AW-1:0] pack_addr(input logic [LW-1:0] w,
                                                input logic [LW-1:0] j);
        return {w, j};
    endfunction

endpackage

// File: rtl/jam_cost_mem.sv
// Cost matrix storage: N*N x CW register array, one write port, one read port.
// Latency: write lands on the next CLK edge; read is combinational (zero cycles).
// Backpressure: none; a write is taken whenever we is high.
module jam_cost_mem #(
    parameter int CW = jam_pkg::CW,
    parameter int AW = jam_pkg::AW
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [CW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [CW-1:0] rdata
);

    logic [CW-1:0] mem_q [2**AW];

    // Store one entry per write; reset wipes the whole matrix so no stale costs survive.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 2**AW; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/jam_cost_server.sv
// Responder for the JAM solver cost lookups: loads an 8x8 matrix, then answers (W,J) queries.
// Latency: Cost is combinational from W/J in SERVE (zero cycles); state changes take one cycle.
// Backpressure: load_ready is high for the whole LOAD phase; load_valid low simply stalls the load.
module jam_cost_server #(
    parameter int N   = jam_pkg::N,
    parameter int CW  = jam_pkg::CW,
    parameter int AW  = jam_pkg::AW,
    parameter int ACW = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [CW-1:0]        load_data,
    input  logic                 load_last,
    input  logic [$clog2(N)-1:0] W,
    input  logic [$clog2(N)-1:0] J,
    output logic [CW-1:0]        Cost,
    output logic                 cost_ready,
    input  logic                 solver_done,
    output logic [ACW-1:0]       access_cnt,
    output logic                 load_err
);

    import jam_pkg::*;

    localparam logic [AW-1:0]  LAST_IDX = AW'(N*N-1);
    localparam logic [ACW-1:0] ACNT_MAX = '1;

    state_t         state_q, state_d;
    logic [AW-1:0]  idx_q, idx_d;
    logic [ACW-1:0] acnt_q, acnt_d;
    logic           err_q, err_d;
    logic           beat;
    logic [CW-1:0]  rdata;

    // Next-state logic: load framing, serve counting and problem restart.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acnt_d  = acnt_q;
        err_d   = err_q;
        beat    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                // A new problem clears the previous error and usage count.
                if (start) begin
                    state_d = LOAD;
                    idx_d   = '0;
                    err_d   = 1'b0;
                    acnt_d  = '0;
                end
            end
            LOAD: begin
                if (load_valid) begin
                    beat  = 1'b1;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        if (load_last) begin
                            state_d = SERVE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end else if (load_last) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            SERVE: begin
                if (acnt_q != ACNT_MAX) begin
                    acnt_d = acnt_q + 1'b1;
                end
                // solver_done takes priority; start is not looked at here.
                if (solver_done) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acnt_q  <= acnt_d;
            err_q   <= err_d;
        end
    end

    jam_cost_mem #(
        .CW(CW),
        .AW(AW)
    ) u_mem (
        .CLK  (CLK),
        .RST  (RST),
        .we   (beat),
        .waddr(idx_q),
        .wdata(load_data),
        .raddr(pack_addr(W, J)),
        .rdata(rdata)
    );

    assign load_ready = (state_q == LOAD);
    assign cost_ready = (state_q == SERVE);
    assign Cost       = cost_ready ? rdata : '0;
    assign access_cnt = acnt_q;
    assign load_err   = err_q;

endmodule
